// File: rtl/mux_n_reg_pkg.sv
// Shared types and helpers for the registered N-way multiplexer.
package mux_n_reg_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    MUX_EMPTY = 1'b0,
    MUX_FULL  = 1'b1
  } mux_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Select fields never collapse to zero width, even for a single channel.
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_reg_if.sv
// Input-channel and output-stage handshake bundle of mux_n_reg.
interface mux_n_reg_if
  import mux_n_reg_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N     = 4,
  localparam int SEL_W = sel_w(N)
);
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_rr_arb.sv
// Round-robin grant: first valid channel at or after rr_ptr, wrapping to the
// lowest valid channel when nothing at or above the pointer is requesting.
module mux_rr_arb #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     in_valid,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [SEL_W-1:0] grant,
  output logic             any_valid
);
  logic [SEL_W-1:0] hi_grant;
  logic             hi_found;

  always_comb begin
    grant    = '0;
    hi_grant = '0;
    hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) grant = SEL_W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i] && (SEL_W'(i) >= rr_ptr)) begin
        hi_grant = SEL_W'(i);
        hi_found = 1'b1;
      end
    end
    if (hi_found) grant = hi_grant;
  end

  assign any_valid = |in_valid;
endmodule

// File: rtl/mux_n_reg.sv
// N-input registered multiplexer with valid/ready on every channel and output.
// Define MUXN_RR_EN to add the rr_mode port and a round-robin arbiter.
module mux_n_reg
  import mux_n_reg_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N     = 4,
  localparam int SEL_W = sel_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] addr,
`ifdef MUXN_RR_EN
  input  logic             rr_mode,
`endif
  mux_n_reg_if.slave       bus
);
  localparam logic [SEL_W:0]   N_L  = (SEL_W + 1)'(N);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

  mux_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, sel_data;
  logic [SEL_W-1:0] sel_q, sel_d, ch, addr_ch;
  logic             load, ch_ok, xfer;

  assign load    = (state_q == MUX_EMPTY) || bus.out_ready;
  assign addr_ch = (N == 1) ? '0 : addr;

`ifdef MUXN_RR_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d, grant;
  logic             any_valid;

  mux_rr_arb #(.N(N), .SEL_W(SEL_W)) u_arb (
    .in_valid  (bus.in_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign ch    = rr_mode ? grant : addr_ch;
  assign ch_ok = rr_mode ? any_valid : ({1'b0, addr_ch} < N_L);

  // Pointer moves only on a round-robin transfer, landing just past the winner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (rr_mode && xfer) rr_ptr_d = (grant == LAST) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  assign ch    = addr_ch;
  assign ch_ok = ({1'b0, addr_ch} < N_L);
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign bus.in_ready[gi] = load && !rst && ch_ok && (ch == SEL_W'(gi));
  end

  assign xfer = |(bus.in_valid & bus.in_ready);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (ch == SEL_W'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // A load with a transfer refills (pass-through when FULL); a load without one drains.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (load) begin
      if (xfer) begin
        state_d = MUX_FULL;
        data_d  = sel_data;
        sel_d   = ch;
      end else begin
        state_d = MUX_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUX_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.out_valid = (state_q == MUX_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_mux_n_reg.sv
// Directed self-checking bench for mux_n_reg (N=4 and N=3 instances).
module tb_mux_n_reg;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] addr4, addr3;
  int         tests  = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  mux_n_reg_if #(.WIDTH(16), .N(4)) bus4 ();
  mux_n_reg_if #(.WIDTH(16), .N(3)) bus3 ();

`ifdef MUXN_RR_EN
  logic rr_mode4, rr_mode3;
`endif

  mux_n_reg #(.WIDTH(16), .N(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr4),
`ifdef MUXN_RR_EN
    .rr_mode (rr_mode4),
`endif
    .bus     (bus4)
  );

  mux_n_reg #(.WIDTH(16), .N(3)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr3),
`ifdef MUXN_RR_EN
    .rr_mode (rr_mode3),
`endif
    .bus     (bus3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input int i, input logic [15:0] v);
    bus4.in_data[i*16 +: 16] = v;
  endtask

  always @(posedge clk) begin
    if (!rst && bus4.out_valid && bus4.out_ready)
      $display("[TB] dut4 pop sel=%0d data=%h", bus4.out_sel, bus4.out_data);
    if (!rst && bus3.out_valid && bus3.out_ready)
      $display("[TB] dut3 pop sel=%0d data=%h", bus3.out_sel, bus3.out_data);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MUXN_RR_EN
    int exp_a [5];
    int exp_b [4];
    rr_mode4 = 1'b0;
    rr_mode3 = 1'b0;
`endif
    rst = 1'b1;
    addr4 = 2'd0;
    addr3 = 2'd0;
    bus4.in_valid  = 4'hF;
    bus4.in_data   = 64'h4444_3333_2222_1111;
    bus4.out_ready = 1'b1;
    bus3.in_valid  = 3'b111;
    bus3.in_data   = 48'h3333_2222_1111;
    bus3.out_ready = 1'b1;

    // Reset
    tick();
    tick();
    chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus4.out_data),  32'd0);
    chk("rst_out_sel",   32'(bus4.out_sel),   32'd0);
    chk("rst_in_ready",  32'(bus4.in_ready),  32'd0);
    chk("rst_in_ready3", 32'(bus3.in_ready),  32'd0);

    // Addressed transfer
    rst = 1'b0;
    bus3.in_valid = 3'b000;
    addr4 = 2'd2;
    set4(2, 16'hBEEF);
    bus4.in_valid = 4'b0100;
    #1;
    chk("addr_in_ready", 32'(bus4.in_ready), 32'b0100);
    tick();
    chk("addr_out_valid", 32'(bus4.out_valid), 32'd1);
    chk("addr_out_data",  32'(bus4.out_data),  32'hBEEF);
    chk("addr_out_sel",   32'(bus4.out_sel),   32'd2);

    bus4.in_valid = 4'b0000;
    tick();
    chk("drain_out_valid", 32'(bus4.out_valid), 32'd0);

    // Stall hold
    addr4 = 2'd0;
    set4(0, 16'h1234);
    bus4.in_valid  = 4'b0001;
    bus4.out_ready = 1'b0;
    tick();
    chk("load_1234_data", 32'(bus4.out_data), 32'h1234);
    for (int i = 0; i < 5; i++) begin
      addr4 = 2'(i);
      bus4.in_data  = {$urandom, $urandom};
      bus4.in_valid = 4'hF;
      #1;
      chk("stall_in_ready", 32'(bus4.in_ready), 32'd0);
      tick();
      chk("stall_out_data",  32'(bus4.out_data),  32'h1234);
      chk("stall_out_sel",   32'(bus4.out_sel),   32'd0);
      chk("stall_out_valid", 32'(bus4.out_valid), 32'd1);
    end
    bus4.out_ready = 1'b1;
    addr4 = 2'd1;
    set4(1, 16'h0001);
    bus4.in_valid = 4'b0010;
    #1;
    chk("unstall_in_ready", 32'(bus4.in_ready), 32'b0010);
    tick();
    chk("unstall_out_data",  32'(bus4.out_data),  32'h0001);
    chk("unstall_out_sel",   32'(bus4.out_sel),   32'd1);
    chk("unstall_out_valid", 32'(bus4.out_valid), 32'd1);

    // Pass-through while FULL
    addr4 = 2'd3;
    set4(3, 16'hABCD);
    bus4.in_valid = 4'b1000;
    tick();
    chk("pass_out_data",  32'(bus4.out_data),  32'hABCD);
    chk("pass_out_sel",   32'(bus4.out_sel),   32'd3);
    chk("pass_out_valid", 32'(bus4.out_valid), 32'd1);

    // Reset while FULL and stalled
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 4'hF;
    addr4 = 2'd0;
    tick();
    chk("prerst_hold", 32'(bus4.out_data), 32'hABCD);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus4.in_ready), 32'd0);
    tick();
    chk("midrst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("midrst_out_data",  32'(bus4.out_data),  32'd0);
    rst = 1'b0;
    bus4.in_valid  = 4'b0000;
    bus4.out_ready = 1'b1;

    // N=3 with out-of-range address
    addr3 = 2'd3;
    bus3.in_valid = 3'b111;
    bus3.in_data  = 48'h5A5A_2222_1111;
    #1;
    chk("n3_oob_in_ready", 32'(bus3.in_ready), 32'd0);
    tick();
    chk("n3_oob_out_valid", 32'(bus3.out_valid), 32'd0);
    tick();
    chk("n3_oob_out_valid2", 32'(bus3.out_valid), 32'd0);
    addr3 = 2'd2;
    #1;
    chk("n3_a2_in_ready", 32'(bus3.in_ready), 32'b100);
    tick();
    chk("n3_a2_out_data", 32'(bus3.out_data), 32'h5A5A);
    chk("n3_a2_out_sel",  32'(bus3.out_sel),  32'd2);
    bus3.in_valid = 3'b000;

`ifdef MUXN_RR_EN
    // Round-robin over all channels, then reset and a sparse pattern
    exp_a = '{0, 1, 2, 3, 0};
    exp_b = '{0, 3, 0, 3};
    rr_mode4 = 1'b1;
    bus4.in_data  = 64'h1003_1002_1001_1000;
    bus4.in_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_all_sel",  32'(bus4.out_sel),  32'(exp_a[k]));
      chk("rr_all_data", 32'(bus4.out_data), 32'h1000 + 32'(exp_a[k]));
    end
    bus4.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rr_rst_out_valid", 32'(bus4.out_valid), 32'd0);
    rst = 1'b0;
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_1001_sel", 32'(bus4.out_sel), 32'(exp_b[k]));
    end
    bus4.in_valid = 4'b0000;
    #1;
    chk("rr_none_in_ready", 32'(bus4.in_ready), 32'd0);
    tick();
    chk("rr_none_out_valid", 32'(bus4.out_valid), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
